// File: rtl/adc_pkg.sv
// Shared definitions for the serial ADC controller.
// Contents:
//   adc_state_t   - frame sequencer states
//   *_DEF         - default timing constants (20 MHz clk, 1 MHz ad_clk)
//   ADC_DATA_W    - bits per conversion
//   max3()        - helper used to size the shared phase counter
package adc_pkg;

    typedef enum logic [2:0] {
        WAIT_CONV,
        SETUP,
        SHIFT_LO,
        SHIFT_HI,
        HOLD
    } adc_state_t;

    localparam int CLK_DIV_DEF   = 10;
    localparam int CS_SETUP_DEF  = 40;
    localparam int CONV_WAIT_DEF = 400;
    localparam int ADC_DATA_W    = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Ports:
//   clk  - destination clock
//   rstn - asynchronous active-low reset, clears both stages to 0
//   d    - asynchronous input
//   q    - synchronized output (two clk cycles of latency)
module sync_2ff (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/adc_serial_ctrl.sv
// Free-running master controller for a TLC549-class 8-bit serial ADC.
// Each frame: hold ad_cs high for the conversion time, drop ad_cs, wait the
// setup time, clock in DATA_W bits MSB first (sampling on ad_clk high), hold,
// then raise ad_cs and publish the code with a one-cycle isdone strobe.
// The first frame after reset is discarded (the ADC returns a stale value).
// Optional macro ADC_AVG4_EN: average four valid frames before publishing.
// Ports:
//   clk     - system clock
//   rstn    - asynchronous active-low reset
//   ad_data - serial data from the ADC (asynchronous, synchronized here)
//   ad_cs   - ADC chip select, active low (registered)
//   ad_clk  - ADC I/O clock (registered)
//   data    - last published conversion code
//   isdone  - one-cycle strobe, coincident with the data update
module adc_serial_ctrl
    import adc_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEF,
    parameter int CS_SETUP  = CS_SETUP_DEF,
    parameter int CONV_WAIT = CONV_WAIT_DEF,
    parameter int DATA_W    = ADC_DATA_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ad_data,
    output logic              ad_cs,
    output logic              ad_clk,
    output logic [DATA_W-1:0] data,
    output logic              isdone
);

    localparam int CNT_MAX = max3(CONV_WAIT, CS_SETUP, CLK_DIV);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONV_WAIT - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);

    adc_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] data_reg;
    logic              first_frame_reg;
    logic              ad_cs_reg, ad_clk_reg, isdone_reg;
    logic              ad_cs_next, ad_clk_next;
    logic              phase_end;
    logic              frame_end;
    logic              ad_data_sync;

    sync_2ff u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (ad_data),
        .q    (ad_data_sync)
    );

    // Each state lasts exactly its programmed number of cycles; the counter
    // restarts from zero on every state exit.
    always_comb begin
        state_next = state_reg;
        phase_end  = 1'b0;
        case (state_reg)
            WAIT_CONV: begin
                phase_end = (cnt_reg == CONV_LAST);
                if (phase_end) state_next = SETUP;
            end
            SETUP: begin
                phase_end = (cnt_reg == SETUP_LAST);
                if (phase_end) state_next = SHIFT_LO;
            end
            SHIFT_LO: begin
                phase_end = (cnt_reg == DIV_LAST);
                if (phase_end) state_next = SHIFT_HI;
            end
            SHIFT_HI: begin
                phase_end = (cnt_reg == DIV_LAST);
                if (phase_end) state_next = (idx_reg == '0) ? HOLD : SHIFT_LO;
            end
            HOLD: begin
                phase_end = (cnt_reg == DIV_LAST);
                if (phase_end) state_next = WAIT_CONV;
            end
            default: begin
                state_next = WAIT_CONV;
                phase_end  = 1'b1;
            end
        endcase
        // Pin levels are decoded from the next state and registered, so the
        // pins change on the same edge as the state and never glitch.
        ad_cs_next  = (state_next == WAIT_CONV);
        ad_clk_next = (state_next == SHIFT_HI);
        frame_end   = (state_reg == HOLD) && phase_end;
    end

`ifdef ADC_AVG4_EN
    logic [DATA_W+1:0] acc_reg;
    logic [1:0]        avg_cnt_reg;
    logic [DATA_W+1:0] sum_next;
    assign sum_next = acc_reg + {2'b00, shift_reg};
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= WAIT_CONV;
            cnt_reg         <= '0;
            idx_reg         <= '0;
            shift_reg       <= '0;
            data_reg        <= '0;
            first_frame_reg <= 1'b1;
            ad_cs_reg       <= 1'b1;
            ad_clk_reg      <= 1'b0;
            isdone_reg      <= 1'b0;
`ifdef ADC_AVG4_EN
            acc_reg         <= '0;
            avg_cnt_reg     <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= phase_end ? '0 : cnt_reg + CNT_W'(1);
            ad_cs_reg  <= ad_cs_next;
            ad_clk_reg <= ad_clk_next;
            isdone_reg <= 1'b0;

            if (state_reg == SETUP && phase_end)
                idx_reg <= IDX_W'(DATA_W - 1);
            else if (state_reg == SHIFT_HI && phase_end && idx_reg != '0)
                idx_reg <= idx_reg - IDX_W'(1);

            // Sample once, at the start of the high phase.
            if (state_reg == SHIFT_HI && cnt_reg == '0)
                shift_reg[idx_reg] <= ad_data_sync;

            if (frame_end) begin
                if (first_frame_reg) begin
                    first_frame_reg <= 1'b0;
                end else begin
`ifdef ADC_AVG4_EN
                    if (avg_cnt_reg == 2'd3) begin
                        data_reg    <= DATA_W'(sum_next >> 2);
                        isdone_reg  <= 1'b1;
                        acc_reg     <= '0;
                        avg_cnt_reg <= '0;
                    end else begin
                        acc_reg     <= sum_next;
                        avg_cnt_reg <= avg_cnt_reg + 2'd1;
                    end
`else
                    data_reg   <= shift_reg;
                    isdone_reg <= 1'b1;
`endif
                end
            end
        end
    end

    assign ad_cs  = ad_cs_reg;
    assign ad_clk = ad_clk_reg;
    assign data   = data_reg;
    assign isdone = isdone_reg;

endmodule
